// File: rtl/master_mem_arb_pkg.sv
// Shared constants for the on-chip RAM arbiter and its round-robin core.
// Optional statistics counters are enabled with MEM_ARB_STATS_EN.
package master_mem_arb_pkg;

    localparam int          DATA_W_DEF = 32;
    localparam int          BE_W       = DATA_W_DEF / 8;
    localparam int          OWNER_W    = 2;
    localparam logic [31:0] RD_OOR_VAL = 32'h0;
    localparam int          STAT_W     = 16;

    function automatic logic [OWNER_W-1:0] next_ptr(
        input logic [OWNER_W-1:0] idx,
        input int                 n
    );
        return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/master_rr_arbiter.sv
// Pure round-robin grant: first requester at or after ptr wins.
// Build option MEM_ARB_STATS_EN does not affect this block.
module master_rr_arbiter
    import master_mem_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]       req,
    input  logic [OWNER_W-1:0] ptr,
    output logic [N-1:0]       grant,
    output logic [OWNER_W-1:0] idx,
    output logic               valid
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!valid && req[j]) begin
                valid    = 1'b1;
                grant[j] = 1'b1;
                idx      = OWNER_W'(j);
            end
        end
    end

endmodule

// File: rtl/master_onchip_mem_arbiter.sv
// Shares the single-port on-chip RAM between NUM_REQ Avalon-MM masters.
// Define MEM_ARB_STATS_EN to add per-master accepted-access counters.
module master_onchip_mem_arbiter
    import master_mem_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 4087
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_read,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
    input  logic [NUM_REQ*BE_W-1:0]     req_byteenable,
    input  logic [NUM_REQ*DATA_W-1:0]   req_writedata,
    output logic [NUM_REQ-1:0]          req_waitrequest,
    output logic [DATA_W-1:0]           req_readdata,
    output logic [NUM_REQ-1:0]          req_readdatavalid,
    output logic [NUM_REQ-1:0]          req_error,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [BE_W-1:0]             mem_byteenable,
    output logic                        mem_chipselect,
    output logic                        mem_write,
    output logic [DATA_W-1:0]           mem_writedata,
    output logic                        mem_clken,
    input  logic [DATA_W-1:0]           mem_readdata,
    input  logic                        stall_req
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]   stat_grants
`endif
);

    logic [NUM_REQ-1:0] active;
    logic [NUM_REQ-1:0] grant;
    logic [OWNER_W-1:0] gidx;
    logic               gvalid;
    logic [OWNER_W-1:0] rr_ptr;
    logic [OWNER_W-1:0] rd_owner;
    logic               rd_pending;
    logic               rd_oor;

    logic [ADDR_W-1:0]  sel_addr;
    logic [BE_W-1:0]    sel_be;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_wr;
    logic               in_range;
    logic               wr_err;
    logic               rd_issue;

    assign active = req_read | req_write;

    // Stall masks every request so no grant and no pointer move occur.
    master_rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr (
        .req  (active & {NUM_REQ{~stall_req}}),
        .ptr  (rr_ptr),
        .grant(grant),
        .idx  (gidx),
        .valid(gvalid)
    );

    always_comb begin
        sel_addr  = '0;
        sel_be    = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr  = req_address[i*ADDR_W +: ADDR_W];
                sel_be    = req_byteenable[i*BE_W +: BE_W];
                sel_wdata = req_writedata[i*DATA_W +: DATA_W];
                sel_wr    = req_write[i];
            end
        end
    end

    assign in_range = 32'(sel_addr) < NUM_WORDS;
    assign wr_err   = gvalid & sel_wr & ~in_range;
    assign rd_issue = gvalid & ~sel_wr;

    assign req_waitrequest = stall_req ? '1 : (active & ~grant);

    assign mem_address    = sel_addr;
    assign mem_byteenable = sel_be;
    assign mem_writedata  = sel_wdata;
    assign mem_chipselect = gvalid & in_range;
    assign mem_write      = gvalid & sel_wr & in_range;
    assign mem_clken      = ~stall_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr     <= '0;
            rd_pending <= 1'b0;
            rd_owner   <= '0;
            rd_oor     <= 1'b0;
        end else begin
            if (gvalid) rr_ptr <= next_ptr(gidx, NUM_REQ);
            rd_pending <= rd_issue;
            if (rd_issue) begin
                rd_owner <= gidx;
                rd_oor   <= ~in_range;
            end
        end
    end

    assign req_readdata = (rd_pending && rd_oor) ? DATA_W'(RD_OOR_VAL)
                                                 : mem_readdata;

    always_comb begin
        req_readdatavalid = '0;
        req_error         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_readdatavalid[i] = rd_pending && (rd_owner == OWNER_W'(i));
            req_error[i] = (rd_pending && rd_oor && (rd_owner == OWNER_W'(i)))
                         || (wr_err && grant[i]);
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [STAT_W-1:0] cnt [NUM_REQ];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (grant[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < NUM_REQ; i++)
            stat_grants[i*STAT_W +: STAT_W] = cnt[i];
    end
`endif

endmodule

// File: tb/tb_master_onchip_mem_arbiter.sv
// Randomized and directed checks of the RAM arbiter against a queue-free
// behavioural model; honours MEM_ARB_STATS_EN for the stats port.
module tb_master_onchip_mem_arbiter;

    localparam int N  = 2;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NW = 4087;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [N-1:0]      req_read = '0;
    logic [N-1:0]      req_write = '0;
    logic [N*AW-1:0]   req_address = '0;
    logic [N*4-1:0]    req_byteenable = '0;
    logic [N*DW-1:0]   req_writedata = '0;
    logic [N-1:0]      req_waitrequest;
    logic [DW-1:0]     req_readdata;
    logic [N-1:0]      req_readdatavalid;
    logic [N-1:0]      req_error;
    logic [AW-1:0]     mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DW-1:0]     mem_writedata;
    logic              mem_clken;
    logic [DW-1:0]     mem_readdata;
    logic              stall_req = 1'b0;
`ifdef MEM_ARB_STATS_EN
    logic [N*16-1:0]   stat_grants;
`endif

    master_onchip_mem_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(NW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_read(req_read), .req_write(req_write),
        .req_address(req_address), .req_byteenable(req_byteenable),
        .req_writedata(req_writedata), .req_waitrequest(req_waitrequest),
        .req_readdata(req_readdata), .req_readdatavalid(req_readdatavalid),
        .req_error(req_error), .mem_address(mem_address),
        .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .stall_req(stall_req)
`ifdef MEM_ARB_STATS_EN
        , .stat_grants(stat_grants)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous RAM with registered read output and clock enable.
    logic [31:0] ram [0:4095];
    logic [31:0] ram_q = '0;
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b])
                        ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                ram_q <= ram[mem_address];
            end
        end
    end
    assign mem_readdata = ram_q;

    // Reference model state
    logic [31:0] shadow [0:4095];
    int          rr = 0;
    bit          pv = 0;
    int          powner = 0;
    bit          poor = 0;
    logic [31:0] pdata = '0;
    int          ngrant [N];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        logic [N-1:0] act, ew, ev, ee;
        int           g;
        bit           oor, wr, ecs;
        logic [AW-1:0] a;
        logic [3:0]   be;
        logic [31:0]  d;
        g = -1; oor = 0; wr = 0; a = '0; be = '0; d = '0;
        if (!reset_n) pv = 0;
        act = req_read | req_write;
        if (!stall_req)
            for (int k = 0; k < N; k++)
                if (g < 0 && act[(rr + k) % N]) g = (rr + k) % N;
        ew = stall_req ? '1 : act;
        if (g >= 0) ew[g] = 1'b0;
        ev = '0; ee = '0;
        if (pv) begin
            ev[powner] = 1'b1;
            if (poor) ee[powner] = 1'b1;
        end
        if (g >= 0) begin
            a   = req_address[g*AW +: AW];
            be  = req_byteenable[g*4 +: 4];
            d   = req_writedata[g*DW +: DW];
            wr  = req_write[g];
            oor = int'(a) >= NW;
            if (wr && oor) ee[g] = 1'b1;
        end
        ecs = (g >= 0) && !oor;
        @(negedge clk);
        chk("waitreq", 64'(req_waitrequest), 64'(ew));
        chk("rdvalid", 64'(req_readdatavalid), 64'(ev));
        chk("error", 64'(req_error), 64'(ee));
        if (pv) chk("rdata", 64'(req_readdata), 64'(pdata));
        chk("clken", 64'(mem_clken), 64'(!stall_req));
        chk("cs", 64'(mem_chipselect), 64'(ecs));
        if (ecs) begin
            chk("addr", 64'(mem_address), 64'(a));
            chk("wr", 64'(mem_write), 64'(wr));
            if (wr) begin
                chk("be", 64'(mem_byteenable), 64'(be));
                chk("wdata", 64'(mem_writedata), 64'(d));
            end
        end
        @(posedge clk);
        pv = 0;
        if (!reset_n) begin
            rr = 0;
            for (int i = 0; i < N; i++) ngrant[i] = 0;
        end else if (g >= 0) begin
            if (ngrant[g] < 65535) ngrant[g]++;
            rr = (g + 1) % N;
            if (wr) begin
                if (!oor)
                    for (int b = 0; b < 4; b++)
                        if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
            end else begin
                pv = 1; powner = g; poor = oor;
                pdata = oor ? 32'h0 : shadow[a];
            end
        end
        #1;
    endtask

    task automatic set_m(input int i, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [3:0] be,
                         input logic [31:0] d);
        req_read[i] = rd;
        req_write[i] = wr;
        req_address[i*AW +: AW] = a;
        req_byteenable[i*4 +: 4] = be;
        req_writedata[i*DW +: DW] = d;
    endtask

    task automatic idle();
        req_read = '0;
        req_write = '0;
    endtask

    task automatic check_stats();
`ifdef MEM_ARB_STATS_EN
        for (int i = 0; i < N; i++)
            chk("stat", 64'(stat_grants[i*16 +: 16]), 64'(ngrant[i]));
`endif
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i] = 32'(i) * 32'h9E3779B9 ^ 32'h5A5A0000;
            shadow[i] = ram[i];
        end
        ram[16] = 32'hCAFEF00D; shadow[16] = 32'hCAFEF00D;
        ram[32] = 32'hFFFFFFFF; shadow[32] = 32'hFFFFFFFF;
        for (int i = 0; i < N; i++) ngrant[i] = 0;

        #1;
        step();
        step();
        check_stats();
        reset_n = 1'b1;
        step();

        // master0 reads preloaded word
        set_m(0, 1, 0, 12'h010, 4'hF, '0);
        step();
        idle();
        step();

        // both masters contend for 8 cycles
        for (int c = 0; c < 8; c++) begin
            set_m(0, 1, 0, 12'(c), 4'hF, '0);
            set_m(1, 1, 0, 12'(c + 100), 4'hF, '0);
            step();
        end
        idle();
        step();

        // partial write then readback
        set_m(1, 0, 1, 12'h020, 4'b0011, 32'h12345678);
        step();
        set_m(1, 1, 0, 12'h020, 4'hF, '0);
        step();
        idle();
        step();

        // first out-of-range word, read and write
        set_m(0, 1, 0, 12'hFF7, 4'hF, '0);
        step();
        set_m(0, 0, 1, 12'hFF7, 4'hF, 32'hDEADBEEF);
        step();
        set_m(0, 1, 0, 12'hFF6, 4'hF, '0);
        step();
        idle();
        step();

        // stall in the middle of a read stream
        for (int c = 0; c < 9; c++) begin
            set_m(0, 1, 0, 12'(40 + c), 4'hF, '0);
            stall_req = (c >= 3 && c < 6);
            step();
        end
        stall_req = 1'b0;
        idle();
        step();

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                int r;
                logic [AW-1:0] a;
                r = $urandom_range(0, 9);
                a = ($urandom_range(0, 15) == 0) ? 12'(4080 + $urandom_range(0, 15))
                                                 : 12'($urandom_range(0, 31));
                set_m(i, (r < 4) || (r == 9), (r >= 4 && r < 7) || (r == 9),
                      a, 4'($urandom), $urandom);
            end
            stall_req = ($urandom_range(0, 9) == 0);
            step();
        end
        stall_req = 1'b0;
        idle();
        step();
        check_stats();

        // reset the cycle after a read issue
        set_m(0, 1, 0, 12'h010, 4'hF, '0);
        step();
        idle();
        reset_n = 1'b0;
        step();
        step();
        check_stats();
        reset_n = 1'b1;
        step();
        set_m(1, 1, 0, 12'h020, 4'hF, '0);
        step();
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
